// File: rtl/mmio_port_responder.sv
// mmio_port_responder
// Memory-mapped I/O responder that sits beside the data memory of a MIPS
// pipeline. It decodes MEM-stage loads/stores inside a 16-byte window,
// buffers stores to OUT_DATA in a small FIFO that drains to PortOut at a
// fixed pace, and synchronizes the asynchronous PortIn for reads.
//
// Register map (byte offset from BASE_ADDRESS, Address[1:0] ignored):
//   0x0 OUT_DATA  W: push WriteData into the FIFO   R: FIFO count
//   0x4 IN_DATA   W: ignored                        R: synchronized PortIn
//   0x8 STATUS    W: bit3=1 clears OVERFLOW         R: {OVF,IN_CHG,EMPTY,FULL}
//   0xC           not decoded (Hit stays low)

module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDRESS = 32'h1001_0100,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          DRAIN_PERIOD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut
);

    // Pointer, occupancy and drain-counter widths. A drain period of 1 still
    // needs a 1-bit counter so the terminal-count compare stays well formed.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DRN_W = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(DRAIN_PERIOD - 1);

    // Register selected by Address[3:2]; the fourth slot is a hole in the map.
    typedef enum logic [1:0] {
        REG_OUT_DATA = 2'd0,
        REG_IN_DATA  = 2'd1,
        REG_STATUS   = 2'd2,
        REG_HOLE     = 2'd3
    } reg_sel_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [31:0]      r_port_out;
    logic             r_overflow;
    logic [7:0]       r_sync1;
    logic [7:0]       r_in_sync;
    logic [7:0]       r_in_prev;
    logic             r_in_changed;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    reg_sel_e w_reg;
    logic     w_hit;
    logic     w_wr_out;
    logic     w_rd_in;
    logic     w_wr_status;
    logic     w_unused_addr_lsb;

    assign w_reg       = reg_sel_e'(Address[3:2]);
    assign w_hit       = (Address[31:4] == BASE_ADDRESS[31:4]) && (w_reg != REG_HOLE);
    assign w_wr_out    = MemWrite && w_hit && (w_reg == REG_OUT_DATA);
    assign w_rd_in     = MemRead  && w_hit && (w_reg == REG_IN_DATA);
    assign w_wr_status = MemWrite && w_hit && (w_reg == REG_STATUS);

    // Byte-lane bits take no part in decoding; accesses are word-granular.
    assign w_unused_addr_lsb = ^Address[1:0];

    assign Hit     = w_hit;
    assign PortOut = r_port_out;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic w_full;
    logic w_empty;
    logic w_drain_tc;
    logic w_pop;
    logic w_push_accept;
    logic w_overflow_set;
    logic w_overflow_clr;
    logic w_in_change;

    assign w_full     = (r_count == FULL_COUNT);
    assign w_empty    = (r_count == '0);
    assign w_drain_tc = (r_drain_cnt == DRAIN_LAST);

    // The pop decision looks only at the current occupancy, so a push into an
    // empty FIFO on the terminal-count cycle waits for the next drain slot.
    assign w_pop = w_drain_tc && !w_empty;

    // A pop frees the slot in the same edge, so full+push+pop is accepted.
    assign w_push_accept  = w_wr_out && (!w_full || w_pop);
    assign w_overflow_set = w_wr_out && w_full && !w_pop;
    assign w_overflow_clr = w_wr_status && WriteData[3];

    assign w_in_change = (r_in_sync != r_in_prev);

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    // Zero-latency load data; reads of unselected or missed addresses give 0.
    always_comb begin
        // NOTE: default assignment first so no path through this block can
        // leave ReadData unassigned and infer a latch.
        ReadData = '0;
        if (MemRead && w_hit) begin
            case (w_reg)
                REG_OUT_DATA: ReadData = {{(32 - CNT_W){1'b0}}, r_count};
                REG_IN_DATA:  ReadData = {24'd0, r_in_sync};
                REG_STATUS:   ReadData = {28'd0, r_overflow, r_in_changed, w_empty, w_full};
                default:      ReadData = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // FIFO storage: write the accepted store at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; pointers and
        // count alone decide which entries are valid, so stale words are
        // never observed and the array can map onto plain RAM/flops.
        if (w_push_accept) begin
            r_mem[r_wr_ptr] <= WriteData;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the depth.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Free-running drain pacer counting 0..DRAIN_PERIOD-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drain_cnt <= '0;
        end else if (w_drain_tc) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
        end
    end

    // Output register: load the FIFO head on each drain pop, else hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port_out <= '0;
        end else if (w_pop) begin
            r_port_out <= r_mem[r_rd_ptr];
        end
    end

    // Sticky OVERFLOW flag; a dropped push and a clear can never coincide
    // because they target different registers, but set is given priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_overflow_set) begin
            r_overflow <= 1'b1;
        end else if (w_overflow_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // Two-flop synchronizer for PortIn plus the previous-value register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_in_sync <= '0;
            r_in_prev <= '0;
        end else begin
            r_sync1   <= PortIn;
            r_in_sync <= r_sync1;
            r_in_prev <= r_in_sync;
        end
    end

    // IN_CHANGED flag: a fresh change wins over a clearing IN_DATA read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_changed <= 1'b0;
        end else if (w_in_change) begin
            r_in_changed <= 1'b1;
        end else if (w_rd_in) begin
            r_in_changed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder
// Directed scenarios followed by a randomized run, all compared every cycle
// against a queue-based behavioural model of the responder.

module tb_mmio_port_responder;

    localparam logic [31:0] BASE  = 32'h1001_0100;
    localparam int          DEPTH = 4;
    localparam int          DP    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;

    mmio_port_responder #(
        .BASE_ADDRESS (BASE),
        .FIFO_DEPTH   (DEPTH),
        .DRAIN_PERIOD (DP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortOut   (PortOut)
    );

    always #5 clk = ~clk;

    // Counters reported in the summary line.
    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state.
    logic [31:0] m_fifo [$];
    logic [7:0]  m_hist [$];   // PortIn sampled at recent edges, newest last
    logic [31:0] m_po;
    bit          m_ovf;
    bit          m_inch;
    int          m_edges;      // edges since the end of reset

    // Observation helpers.
    bit          chk_en = 1'b0;
    logic [7:0]  pin_drv = 8'h00;
    logic [31:0] last_rd;
    logic        last_hit;
    logic [31:0] last_po;
    logic [31:0] seen_po = 32'h0;
    logic [31:0] chg_val [$];
    int          chg_cyc [$];
    int          ncyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_in_sync();
        return m_hist[m_hist.size() - 2];
    endfunction

    function automatic logic [7:0] m_in_prev();
        return m_hist[m_hist.size() - 3];
    endfunction

    function automatic logic exp_hit(input logic [31:0] a);
        return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
    endfunction

    function automatic logic [31:0] exp_read(input logic mr, input logic [31:0] a);
        logic [1:0] off;
        off = a[3:2];
        if (!mr || !exp_hit(a)) return 32'h0;
        case (off)
            2'd0:    return 32'(m_fifo.size());
            2'd1:    return {24'h0, m_in_sync()};
            default: return {28'h0, m_ovf, m_inch, m_fifo.size() == 0, m_fifo.size() == DEPTH};
        endcase
    endfunction

    // Advance the model by one rising edge.
    task automatic model_edge(input logic mw, input logic mr, input logic [31:0] a,
                              input logic [31:0] wd, input logic rst);
        logic       hit;
        logic [1:0] off;
        bit         tc;
        hit = exp_hit(a);
        off = a[3:2];
        if (rst) begin
            m_fifo.delete();
            m_hist = '{8'h0, 8'h0, 8'h0};
            m_po    = 32'h0;
            m_ovf   = 1'b0;
            m_inch  = 1'b0;
            m_edges = 0;
            return;
        end
        tc = (m_edges % DP) == (DP - 1);
        m_inch = (m_in_sync() != m_in_prev()) || (m_inch && !(mr && hit && off == 2'd1));
        if (mw && hit && off == 2'd2 && wd[3]) m_ovf = 1'b0;
        if (tc && m_fifo.size() > 0) m_po = m_fifo.pop_front();
        if (mw && hit && off == 2'd0) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(wd);
            else m_ovf = 1'b1;
        end
        m_hist.push_back(PortIn);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
        m_edges++;
    endtask

    // One bus cycle: drive, compare at the falling edge, advance the model.
    task automatic step(input logic mw, input logic mr, input logic [31:0] a,
                        input logic [31:0] wd, input logic rst);
        MemWrite  = mw;
        MemRead   = mr;
        Address   = a;
        WriteData = wd;
        PortIn    = pin_drv;
        reset     = rst;
        @(negedge clk);
        last_rd  = ReadData;
        last_hit = Hit;
        last_po  = PortOut;
        if (chk_en) begin
            check("hit", {31'h0, Hit}, {31'h0, exp_hit(a)});
            check("read_data", ReadData, exp_read(mr, a));
            check("port_out", PortOut, m_po);
        end
        if (PortOut !== seen_po) begin
            chg_val.push_back(PortOut);
            chg_cyc.push_back(ncyc);
            seen_po = PortOut;
        end
        @(posedge clk);
        model_edge(mw, mr, a, wd, rst);
        ncyc++;
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        chg_val.delete();
        chg_cyc.delete();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 1'b1, a, 32'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] status_before;
        logic [31:0] exp_order [5];

        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
        Address = 32'h0; WriteData = 32'h0; PortIn = 8'h0;

        // Reset with three entries queued.
        do_reset();
        chk_en = 1'b1;
        wr(BASE, 32'h1); wr(BASE, 32'h2); wr(BASE, 32'h3);
        rd(BASE);
        check("pre_reset_count", last_rd, 32'h3);
        do_reset();
        rd(BASE + 32'h8);
        check("reset_status", last_rd, 32'h2);
        check("reset_portout", last_po, 32'h0);
        rd(BASE);
        check("reset_count", last_rd, 32'h0);

        // Store then drain: values appear in order, one drain period apart.
        do_reset();
        seen_po = last_po;
        wr(BASE, 32'hA5); wr(BASE, 32'h5A); wr(BASE, 32'h3C);
        idle(28);
        check("drain_changes", 32'(chg_val.size()), 32'd3);
        if (chg_val.size() == 3) begin
            check("drain_v0", chg_val[0], 32'hA5);
            check("drain_v1", chg_val[1], 32'h5A);
            check("drain_v2", chg_val[2], 32'h3C);
            check("drain_gap0", 32'(chg_cyc[1] - chg_cyc[0]), 32'd8);
            check("drain_gap1", 32'(chg_cyc[2] - chg_cyc[1]), 32'd8);
        end
        rd(BASE + 32'h8);
        check("drain_status", last_rd, 32'h2);

        // Overflow: five stores before the first terminal count.
        do_reset();
        for (int i = 0; i < 5; i++) wr(BASE, 32'h100 + 32'(i));
        rd(BASE + 32'h8);
        check("ovf_status", last_rd, 32'h9);
        rd(BASE);
        check("ovf_count", last_rd, 32'h4);
        wr(BASE + 32'h8, 32'h8);
        rd(BASE + 32'h8);
        check("ovf_cleared", last_rd & 32'h8, 32'h0);

        // Full FIFO, push on the terminal-count cycle.
        do_reset();
        wr(BASE, 32'h11); wr(BASE, 32'h22); wr(BASE, 32'h33); wr(BASE, 32'h44);
        idle(3);
        seen_po = last_po;
        chg_val.delete();
        chg_cyc.delete();
        wr(BASE, 32'h55);
        rd(BASE);
        check("fpp_count", last_rd, 32'h4);
        rd(BASE + 32'h8);
        check("fpp_status", last_rd, 32'h1);
        idle(40);
        exp_order = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        check("fpp_changes", 32'(chg_val.size()), 32'd5);
        if (chg_val.size() == 5) begin
            for (int i = 0; i < 5; i++) check("fpp_order", chg_val[i], exp_order[i]);
        end

        // Input synchronizer and IN_CHANGED.
        do_reset();
        pin_drv = 8'h7E;
        idle(1);
        rd(BASE + 32'h4);
        check("in_before_2nd_edge", last_rd, 32'h0);
        rd(BASE + 32'h4);
        check("in_after_2nd_edge", last_rd, 32'h7E);
        rd(BASE + 32'h8);
        check("inch_set", (last_rd >> 2) & 32'h1, 32'h1);
        rd(BASE + 32'h4);
        rd(BASE + 32'h8);
        check("inch_cleared", (last_rd >> 2) & 32'h1, 32'h0);
        pin_drv = 8'h03;
        idle(2);
        rd(BASE + 32'h4);
        rd(BASE + 32'h8);
        check("inch_set_wins", (last_rd >> 2) & 32'h1, 32'h1);

        // Decode holes and aliasing.
        rd(BASE + 32'h8);
        status_before = last_rd;
        step(1'b1, 1'b1, BASE + 32'hC, 32'hFFFF_FFFF, 1'b0);
        check("hole_hit", {31'h0, last_hit}, 32'h0);
        check("hole_rdata", last_rd, 32'h0);
        step(1'b1, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 1'b0);
        check("above_hit", {31'h0, last_hit}, 32'h0);
        check("above_rdata", last_rd, 32'h0);
        rd(BASE + 32'h8);
        check("decode_no_change", last_rd, status_before);
        rd(BASE);
        check("decode_count", last_rd, 32'h0);
        rd(BASE + 32'h5);
        check("alias_hit", {31'h0, last_hit}, 32'h1);
        check("alias_in", last_rd, 32'h03);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic [31:0] a;
            logic [31:0] d;
            r = int'($urandom_range(0, 99));
            if (r < 75)      a = BASE + $urandom_range(0, 15);
            else if (r < 88) a = BASE + 32'h10 + $urandom_range(0, 15);
            else             a = $urandom;
            d = $urandom;
            if ($urandom_range(0, 99) < 15) pin_drv = 8'($urandom);
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 50, a, d,
                 $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mmio_port_responder.md
# mmio_port_responder

Memory-mapped I/O responder on the data-memory side of the MIPS pipeline. It decodes MEM-stage load/store accesses falling in its address window, drives the processor's `PortOut`, and synchronizes and samples `PortIn`. Stores to the output register are buffered in a small FIFO and drained to `PortOut` at a fixed pace. It sits beside the data memory, and the core muxes its `ReadData` in when `Hit` is high.

## Interface
- `BASE_ADDRESS`, default 32'h1001_0100: window base; bits [3:0] must be zero.
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, 2..16.
- `DRAIN_PERIOD`, default 8: cycles between FIFO drain opportunities; must be ≥ 1.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `MemWrite` input, 1 bit: MEM-stage store strobe.
- `MemRead` input, 1 bit: MEM-stage load strobe.
- `Address` input, 32 bits: byte address (ALU result).
- `WriteData` input, 32 bits: store data (rt value).
- `PortIn` input, 8 bits: asynchronous external input.
- `ReadData` output, 32 bits: load data; combinational.
- `Hit` output, 1 bit: `Address` decodes to a valid register; combinational.
- `PortOut` output, 32 bits: registered external output.

## Operation
- Decode: `Hit` = (`Address[31:4]` == `BASE_ADDRESS[31:4]`) and (`Address[3:2]` != 2'b11). `Address[1:0]` is ignored. A strobe without `Hit` has no effect.
- Offset 0x0, OUT_DATA:
  - Write pushes `WriteData` into the FIFO.
  - Read returns the FIFO count, zero-extended.
- Offset 0x4, IN_DATA:
  - Read returns the synchronized `PortIn` (`in_sync`), zero-extended.
  - A read clears the IN_CHANGED flag at the clock edge.
  - A write is ignored.
- Offset 0x8, STATUS:
  - Read layout: bit0 FULL, bit1 EMPTY, bit2 IN_CHANGED, bit3 OVERFLOW, others 0.
  - Writing 1 to bit3 clears OVERFLOW. All other bits are read-only.
- Input path:
  - Two-flop synchronizer produces `in_sync`. A third register holds `in_prev`.
  - IN_CHANGED is set when `in_sync` != `in_prev`.
  - If a set and a clearing read occur in the same cycle, set wins.
- FIFO:
  - Circular buffer with read/write pointers of width log2(`FIFO_DEPTH`); pointers wrap modulo depth.
  - Count has width log2(`FIFO_DEPTH`)+1.
  - Push while full with no pop in the same cycle: data is dropped, count is unchanged, OVERFLOW is set (sticky).
- Drain:
  - A free-running counter runs 0..`DRAIN_PERIOD`-1 and wraps.
  - At terminal count, if the FIFO is non-empty, the head is popped into `PortOut`.
  - Otherwise `PortOut` holds its value.
- Simultaneous push and pop:
  - Both occur; count is unchanged.
  - Full plus pop plus push is accepted, with no overflow.
  - Empty plus push at terminal count: the push is accepted, no pop happens that cycle, and the drain waits for the next terminal count.
- `MemRead` and `MemWrite` asserted together to the same register: both side effects apply.

## Timing
- Reset (synchronous) clears:
  - `PortOut` to 0.
  - FIFO pointers and count to 0, so EMPTY=1 and FULL=0.
  - OVERFLOW and IN_CHANGED to 0.
  - Synchronizer and `in_prev` to 0.
  - Drain counter to 0.
- `ReadData` and `Hit` have zero latency: they are valid in the same cycle as `Address`/`MemRead`. `ReadData` is 0 when `Hit`=0 or `MemRead`=0.
- Register updates (push, flag clears) commit at the rising edge ending the access cycle. A read of STATUS in the next cycle sees the new state.
- `PortIn` to `in_sync`: 2 cycles. IN_CHANGED is set 3 edges after a `PortIn` change.
- Store to `PortOut` with an empty FIFO: 1 to `DRAIN_PERIOD` cycles after the push edge, depending on counter phase.
- Reset mid-operation discards FIFO contents. No drain occurs in the reset cycle.

## Test plan
- Reset: assert `reset` for 2 cycles with the FIFO holding 3 entries. Required: `PortOut`=0, STATUS read=0x2, OUT_DATA read=0.
- Store then drain: store 0xA5, 0x5A, 0x3C to BASE+0 with `DRAIN_PERIOD`=8. Required: `PortOut` takes 0xA5, 0x5A, 0x3C in order, exactly 8 cycles apart; STATUS ends at 0x2.
- Overflow: 5 back-to-back stores (depth 4) avoiding a terminal count.
  - Required: 5th store dropped, STATUS=0x9, count=4.
  - Then store 0x8 to BASE+8. Required: OVERFLOW clears.
- Full, push and pop together: with the FIFO full, store on the terminal-count cycle. Required: count stays 4, OVERFLOW stays 0, the new value appears last in drain order.
- Input sync and change: `PortIn` changes 0x00 to 0x7E.
  - Required: IN_DATA reads 0x7E from the 2nd edge; STATUS bit2 is set after the 3rd edge.
  - Read IN_DATA. Required: bit2 is cleared. A change in the same cycle as the read keeps bit2 set.
- Decode: access BASE+0xC and BASE+0x10 with both strobes. Required: `Hit`=0, `ReadData`=0, no state change. BASE+0x5 aliases to IN_DATA.
